cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl_pkg.sv | 23 ++
 rtl/run_watchdog.sv | 39 +++
 rtl/cpu_run_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run controller and the CPU core: opcode
// constants, controller FSM encodings and counter widths.
package cpu_run_ctrl_pkg;

  localparam int CYC_W = 16;
  localparam int OP_W  = 5;

  localparam logic [OP_W-1:0] OP_HALT = 5'b00001;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4,
    ST_TMO   = 3'd5
  } run_state_e;

  function automatic logic is_busy_state(input run_state_e s);
    return (s == ST_LOAD) || (s == ST_START) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/run_watchdog.sv
// Run-cycle counter with saturating increment and watchdog compare against
// a host-programmed limit (limit 0 disables the watchdog).
module run_watchdog
  import cpu_run_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             count_en,
  input  logic [CYC_W-1:0] max_cycles,
  output logic [CYC_W-1:0] run_cycles,
  output logic             expire
);

  logic [CYC_W-1:0] cnt_q;
  logic [CYC_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CYC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the last permitted RUN cycle so the FSM leaves RUN after exactly max_cycles cycles.
  assign expire     = (max_cycles != '0) && (cnt_q == (max_cycles - CYC_W'(1)));
  assign run_cycles = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Host-side run controller: streams a program into instruction memory, then
// starts the CPU, watches for HALT or a watchdog timeout and reports status.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int IMEM_AW = 8,
  parameter int IMEM_DW = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_req,
  input  logic               run_req,
  input  logic               abort,
  input  logic               ack,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic [IMEM_DW-1:0] host_data,
  input  logic               host_last,
  output logic               im_we,
  output logic [IMEM_AW-1:0] im_addr,
  output logic [IMEM_DW-1:0] im_wdata,
  output logic               cpu_reset,
  output logic               cpu_enable,
  output logic               cpu_start,
  input  logic [4:0]         cpu_wb_op,
  input  logic [15:0]        max_cycles,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               loaded,
  output logic [IMEM_AW:0]   prog_len,
  output logic [15:0]        run_cycles
);

  localparam logic [IMEM_AW-1:0] ADDR_MAX = '1;

  run_state_e         state_q, state_d;
  logic [IMEM_AW-1:0] waddr_q, waddr_d;
  logic [IMEM_AW:0]   prog_len_q, prog_len_d;
  logic               loaded_q, loaded_d;
  logic               im_we_q, im_we_d;
  logic [IMEM_AW-1:0] im_addr_q, im_addr_d;
  logic [IMEM_DW-1:0] im_wdata_q, im_wdata_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               cpu_enable_q, cpu_enable_d;
  logic               cpu_start_q, cpu_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;

  logic accept;
  logic abort_hit;
  logic wd_clear;
  logic wd_count_en;
  logic wd_expire;

  assign host_ready  = (state_q == ST_LOAD);
  assign accept      = host_valid && host_ready;
  assign abort_hit   = abort && (state_q != ST_IDLE);
  assign wd_clear    = (state_d == ST_START);
  assign wd_count_en = (state_q == ST_RUN);

  run_watchdog u_run_watchdog (
    .clock      (clock),
    .reset      (reset),
    .clear      (wd_clear),
    .count_en   (wd_count_en),
    .max_cycles (max_cycles),
    .run_cycles (run_cycles),
    .expire     (wd_expire)
  );

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    prog_len_d  = prog_len_q;
    loaded_d    = loaded_q;
    im_we_d     = 1'b0;
    im_addr_d   = im_addr_q;
    im_wdata_d  = im_wdata_q;
    cpu_reset_d = cpu_reset_q;

    if (abort_hit) begin
      state_d     = ST_IDLE;
      cpu_reset_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_req) begin
            state_d     = ST_LOAD;
            waddr_d     = '0;
            prog_len_d  = '0;
            loaded_d    = 1'b0;
            cpu_reset_d = 1'b0;
          end else if (run_req && loaded_q) begin
            state_d     = ST_START;
            cpu_reset_d = 1'b1;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            im_we_d    = 1'b1;
            im_addr_d  = waddr_q;
            im_wdata_d = host_data;
            prog_len_d = prog_len_q + (IMEM_AW+1)'(1);
            // The top address ends the load instead of wrapping the write pointer.
            if (host_last || (waddr_q == ADDR_MAX)) begin
              loaded_d = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              waddr_d = waddr_q + IMEM_AW'(1);
            end
          end
        end
        ST_START: state_d = ST_RUN;
        ST_RUN: begin
          if (cpu_wb_op == OP_HALT) begin
            state_d = ST_DONE;
          end else if (wd_expire) begin
            state_d = ST_TMO;
          end
        end
        ST_DONE, ST_TMO: begin
          if (ack) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Status outputs are registered copies of the state being entered.
    busy_d       = is_busy_state(state_d);
    done_d       = (state_d == ST_DONE);
    timeout_d    = (state_d == ST_TMO);
    cpu_enable_d = (state_d == ST_START) || (state_d == ST_RUN);
    cpu_start_d  = (state_d == ST_START);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      waddr_q      <= '0;
      prog_len_q   <= '0;
      loaded_q     <= 1'b0;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      cpu_reset_q  <= 1'b0;
      cpu_enable_q <= 1'b0;
      cpu_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      waddr_q      <= waddr_d;
      prog_len_q   <= prog_len_d;
      loaded_q     <= loaded_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      cpu_enable_q <= cpu_enable_d;
      cpu_start_q  <= cpu_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign im_we      = im_we_q;
  assign im_addr    = im_addr_q;
  assign im_wdata   = im_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign cpu_enable = cpu_enable_q;
  assign cpu_start  = cpu_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign loaded     = loaded_q;
  assign prog_len   = prog_len_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: program load, HALT run, watchdog timeout,
// full-memory load, abort, command priority and mid-operation reset.
module tb_cpu_run_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_req, run_req, abort, ack;
  logic        host_valid, host_ready, host_last;
  logic [15:0] host_data;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [15:0] im_wdata;
  logic        cpu_reset, cpu_enable, cpu_start;
  logic [4:0]  cpu_wb_op;
  logic [15:0] max_cycles;
  logic        busy, done, timeout, loaded;
  logic [8:0]  prog_len;
  logic [15:0] run_cycles;

  int n_checks = 0;
  int n_errs   = 0;

  logic [15:0] prog3 [3] = '{16'h4101, 16'h4202, 16'h0800};

  always #5 clock = ~clock;

  cpu_run_ctrl #(.IMEM_AW(8), .IMEM_DW(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_req   (load_req),
    .run_req    (run_req),
    .abort      (abort),
    .ack        (ack),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_data  (host_data),
    .host_last  (host_last),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_reset  (cpu_reset),
    .cpu_enable (cpu_enable),
    .cpu_start  (cpu_start),
    .cpu_wb_op  (cpu_wb_op),
    .max_cycles (max_cycles),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .loaded     (loaded),
    .prog_len   (prog_len),
    .run_cycles (run_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, ".host_ready"}, 32'(host_ready), 32'd0);
    chk({pfx, ".im_we"},      32'(im_we),      32'd0);
    chk({pfx, ".im_addr"},    32'(im_addr),    32'd0);
    chk({pfx, ".im_wdata"},   32'(im_wdata),   32'd0);
    chk({pfx, ".cpu_reset"},  32'(cpu_reset),  32'd0);
    chk({pfx, ".cpu_enable"}, 32'(cpu_enable), 32'd0);
    chk({pfx, ".cpu_start"},  32'(cpu_start),  32'd0);
    chk({pfx, ".busy"},       32'(busy),       32'd0);
    chk({pfx, ".done"},       32'(done),       32'd0);
    chk({pfx, ".timeout"},    32'(timeout),    32'd0);
    chk({pfx, ".loaded"},     32'(loaded),     32'd0);
    chk({pfx, ".prog_len"},   32'(prog_len),   32'd0);
    chk({pfx, ".run_cycles"}, 32'(run_cycles), 32'd0);
  endtask

  initial begin
    reset = 1'b0; load_req = 1'b0; run_req = 1'b0; abort = 1'b0; ack = 1'b0;
    host_valid = 1'b0; host_last = 1'b0; host_data = '0;
    cpu_wb_op = '0; max_cycles = '0;
    tick(); tick();
    chk_reset_vals("por");
    reset = 1'b1;
    tick();

    // Three-word program with host_last on the final beat
    load_req = 1'b1; tick(); load_req = 1'b0;
    chk("ld3.ready", 32'(host_ready), 32'd1);
    chk("ld3.busy",  32'(busy),       32'd1);
    for (int i = 0; i < 3; i++) begin
      host_valid = 1'b1; host_data = prog3[i]; host_last = (i == 2);
      tick();
      chk($sformatf("ld3.we%0d", i),    32'(im_we),    32'd1);
      chk($sformatf("ld3.addr%0d", i),  32'(im_addr),  32'(i));
      chk($sformatf("ld3.wdata%0d", i), 32'(im_wdata), 32'(prog3[i]));
      chk($sformatf("ld3.len%0d", i),   32'(prog_len), 32'(i + 1));
    end
    host_valid = 1'b0; host_last = 1'b0;
    chk("ld3.loaded",   32'(loaded),     32'd1);
    chk("ld3.ready_lo", 32'(host_ready), 32'd0);
    tick();
    chk("ld3.we_off",   32'(im_we),      32'd0);
    chk("ld3.cpu_rst",  32'(cpu_reset),  32'd0);

    // Run ending with HALT ten cycles after cpu_start
    run_req = 1'b1; tick(); run_req = 1'b0;
    chk("halt.start",   32'(cpu_start),  32'd1);
    chk("halt.en0",     32'(cpu_enable), 32'd1);
    chk("halt.rst0",    32'(cpu_reset),  32'd1);
    chk("halt.busy",    32'(busy),       32'd1);
    chk("halt.rc0",     32'(run_cycles), 32'd0);
    tick();
    chk("halt.start_1", 32'(cpu_start),  32'd0);
    chk("halt.rc1",     32'(run_cycles), 32'd0);
    for (int i = 0; i < 9; i++) tick();
    chk("halt.rc9",     32'(run_cycles), 32'd9);
    chk("halt.en9",     32'(cpu_enable), 32'd1);
    cpu_wb_op = 5'b00001;
    tick();
    cpu_wb_op = 5'b00000;
    chk("halt.done",    32'(done),       32'd1);
    chk("halt.en_off",  32'(cpu_enable), 32'd0);
    chk("halt.rc10",    32'(run_cycles), 32'd10);
    chk("halt.rst_hold",32'(cpu_reset),  32'd1);
    chk("halt.busy_lo", 32'(busy),       32'd0);
    tick();
    chk("halt.frozen",  32'(run_cycles), 32'd10);
    chk("halt.done2",   32'(done),       32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("halt.ack",     32'(done),       32'd0);
    chk("halt.idle_rst",32'(cpu_reset),  32'd1);

    // Watchdog timeout after five RUN cycles
    max_cycles = 16'd5;
    run_req = 1'b1; tick(); run_req = 1'b0;
    chk("tmo.start",    32'(cpu_start),  32'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("tmo.pre",      32'(timeout),    32'd0);
    chk("tmo.pre_en",   32'(cpu_enable), 32'd1);
    chk("tmo.pre_rc",   32'(run_cycles), 32'd4);
    tick();
    chk("tmo.flag",     32'(timeout),    32'd1);
    chk("tmo.en_off",   32'(cpu_enable), 32'd0);
    chk("tmo.rc",       32'(run_cycles), 32'd5);
    chk("tmo.rst_hold", 32'(cpu_reset),  32'd1);
    tick();
    chk("tmo.hold",     32'(timeout),    32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("tmo.ack",      32'(timeout),    32'd0);
    chk("tmo.busy",     32'(busy),       32'd0);
    max_cycles = 16'd0;

    // Full-memory load without host_last stops at the top address
    load_req = 1'b1; tick(); load_req = 1'b0;
    chk("ld256.rst_lo", 32'(cpu_reset),  32'd0);
    chk("ld256.clr",    32'(loaded),     32'd0);
    chk("ld256.len0",   32'(prog_len),   32'd0);
    host_valid = 1'b1; host_last = 1'b0;
    for (int i = 0; i < 256; i++) begin
      host_data = 16'(i) ^ 16'hA500;
      tick();
      chk($sformatf("ld256.beat%0d", i), {23'd0, im_we, im_addr}, 32'h100 | 32'(i));
    end
    chk("ld256.len",    32'(prog_len),   32'd256);
    chk("ld256.wdata",  32'(im_wdata),   32'hA5FF);
    chk("ld256.loaded", 32'(loaded),     32'd1);
    chk("ld256.ready",  32'(host_ready), 32'd0);
    tick();
    chk("ld256.no_we",  32'(im_we),      32'd0);
    chk("ld256.addr",   32'(im_addr),    32'd255);
    chk("ld256.len2",   32'(prog_len),   32'd256);
    host_valid = 1'b0;

    // Abort after two beats; a beat offered with the abort is dropped
    load_req = 1'b1; tick(); load_req = 1'b0;
    host_valid = 1'b1; host_data = 16'h1111; tick();
    host_data = 16'h2222; tick();
    chk("abt.len2",     32'(prog_len),   32'd2);
    host_data = 16'h3333; abort = 1'b1; tick(); abort = 1'b0; host_valid = 1'b0;
    chk("abt.ready",    32'(host_ready), 32'd0);
    chk("abt.loaded",   32'(loaded),     32'd0);
    chk("abt.busy",     32'(busy),       32'd0);
    chk("abt.no_we",    32'(im_we),      32'd0);
    chk("abt.len",      32'(prog_len),   32'd2);
    run_req = 1'b1; tick(); run_req = 1'b0;
    chk("abt.run_ign",  32'(cpu_start),  32'd0);
    chk("abt.run_en",   32'(cpu_enable), 32'd0);
    chk("abt.run_busy", 32'(busy),       32'd0);

    // Reset landing on an accepted beat leaves no write behind
    load_req = 1'b1; tick(); load_req = 1'b0;
    host_valid = 1'b1; host_data = 16'h5A5A; reset = 1'b0; tick();
    host_valid = 1'b0; reset = 1'b1;
    chk("rstld.no_we",  32'(im_we),      32'd0);
    chk("rstld.ready",  32'(host_ready), 32'd0);

    // Load one word, then load_req and run_req together must choose LOAD
    load_req = 1'b1; tick(); load_req = 1'b0;
    host_valid = 1'b1; host_last = 1'b1; host_data = 16'hBEEF; tick();
    host_valid = 1'b0; host_last = 1'b0;
    chk("both.pre_ld",  32'(loaded),     32'd1);
    load_req = 1'b1; run_req = 1'b1; tick(); load_req = 1'b0; run_req = 1'b0;
    chk("both.ready",   32'(host_ready), 32'd1);
    chk("both.start",   32'(cpu_start),  32'd0);
    chk("both.loaded",  32'(loaded),     32'd0);
    host_valid = 1'b1; host_last = 1'b1; host_data = 16'hC0DE; tick();
    host_valid = 1'b0; host_last = 1'b0;
    chk("both.wdata",   32'(im_wdata),   32'hC0DE);

    // Reset in the middle of a run
    max_cycles = 16'd100;
    run_req = 1'b1; tick(); run_req = 1'b0;
    tick(); tick(); tick();
    chk("rstrun.en",    32'(cpu_enable), 32'd1);
    chk("rstrun.rc",    32'(run_cycles), 32'd2);
    reset = 1'b0; tick();
    chk_reset_vals("rstrun");
    reset = 1'b1; max_cycles = 16'd0;
    tick();
    chk("rstrun.idle",  32'(busy),       32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
